// File: rtl/pipe_mux_n.sv
// pipe_mux_n: registered N-to-1 word mux with valid/ready flow control, flush and sticky select error.
// Define PIPE_MUX_SKID_EN for a two-entry skid buffer with a registered in_ready; default is a single output register.
module pipe_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_IN*WIDTH-1:0] i_data_in,
  input  logic [SEL_W-1:0]        i_sel,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic                    i_flush,
  output logic [WIDTH-1:0]        o_data_out,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_sel_err
);

  logic [WIDTH-1:0] w_word;
  logic [31:0]      w_sel_ext;
  logic             w_sel_bad;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_take;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_sel_err;

  // Widen the select so the range test stays meaningful when 2**SEL_W == NUM_IN.
  assign w_sel_ext = 32'(i_sel);
  assign w_sel_bad = (w_sel_ext >= 32'(NUM_IN));

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_sel_ext == 32'(k)) begin
        w_word = i_data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_accept = i_in_valid & w_in_ready;
  assign w_take   = r_out_valid & i_out_ready;

  // A bad select counts even when a simultaneous flush throws the beat away.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_sel_bad) begin
      r_sel_err <= 1'b1;
    end
  end

`ifdef PIPE_MUX_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  assign w_in_ready = r_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= EMPTY;
      r_data_out  <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (i_flush) begin
      r_state     <= EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_data_out  <= w_word;
            r_out_valid <= 1'b1;
            r_state     <= ONE;
          end
        end
        ONE: begin
          if (w_accept && !w_take) begin
            r_skid     <= w_word;
            r_in_ready <= 1'b0;
            r_state    <= TWO;
          end else if (w_accept) begin
            r_data_out <= w_word;
          end else if (w_take) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          // Skid word is older than anything upstream, so it moves up first.
          if (w_take) begin
            r_data_out <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= EMPTY;
        end
      endcase
    end
  end
`else
  // Ready whenever the output register is free or being drained this cycle.
  assign w_in_ready = !r_out_valid | i_out_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (i_flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_data_out  <= w_word;
      r_out_valid <= 1'b1;
    end else if (w_take) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

  assign o_in_ready  = w_in_ready;
  assign o_data_out  = r_data_out;
  assign o_out_valid = r_out_valid;
  assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed self-checking bench for pipe_mux_n (4-channel and 3-channel instances).
// Expected values depend on whether PIPE_MUX_SKID_EN is defined for the build.
module tb_pipe_mux_n;

  logic          clk;
  logic          rst;
  logic [127:0]  data4;
  logic [1:0]    sel;
  logic          inValid;
  logic          flush;
  logic          outReady;

  logic          inReady4, outValid4, selErr4;
  logic [31:0]   dataOut4;
  logic          inReady3, outValid3, selErr3;
  logic [31:0]   dataOut3;

  int nChecks = 0;
  int nPass   = 0;

  pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dut4 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_in  (data4),
    .i_sel      (sel),
    .i_in_valid (inValid),
    .o_in_ready (inReady4),
    .i_flush    (flush),
    .o_data_out (dataOut4),
    .o_out_valid(outValid4),
    .i_out_ready(outReady),
    .o_sel_err  (selErr4)
  );

  pipe_mux_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dut3 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_in  (data4[95:0]),
    .i_sel      (sel),
    .i_in_valid (inValid),
    .o_in_ready (inReady3),
    .i_flush    (flush),
    .o_data_out (dataOut3),
    .o_out_valid(outValid3),
    .i_out_ready(outReady),
    .o_sel_err  (selErr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's inputs shortly after the active edge, then let them settle.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [1:0] s, input logic ordy);
    rst      = r;
    flush    = f;
    inValid  = v;
    sel      = s;
    outReady = ordy;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    data4 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    rst = 1'b1; flush = 1'b0; inValid = 1'b0; sel = 2'd0; outReady = 1'b1;

    // Reset state
    applyStimulus(1, 0, 0, 0, 1); tick;
    checkOutput("rst_valid", 32'(outValid4), 32'd0);
    checkOutput("rst_data",  dataOut4, 32'h0);
    checkOutput("rst_err4",  32'(selErr4), 32'd0);
    checkOutput("rst_err3",  32'(selErr3), 32'd0);
    checkOutput("rst_ready", 32'(inReady4), 32'd1);

    // Streaming selects with downstream always ready
    applyStimulus(0, 0, 1, 2, 1); tick;
    checkOutput("sel2_data4",  dataOut4, 32'h33333333);
    checkOutput("sel2_valid4", 32'(outValid4), 32'd1);
    checkOutput("sel2_data3",  dataOut3, 32'h33333333);
    applyStimulus(0, 0, 1, 3, 1); tick;
    checkOutput("sel3_data4", dataOut4, 32'h44444444);
    checkOutput("sel3_err4",  32'(selErr4), 32'd0);
    checkOutput("sel3_data3", dataOut3, 32'h00000000);
    checkOutput("sel3_err3",  32'(selErr3), 32'd1);
    applyStimulus(0, 0, 1, 1, 1); tick;
    checkOutput("sel1_data4",  dataOut4, 32'h22222222);
    checkOutput("sticky_err3", 32'(selErr3), 32'd1);
    applyStimulus(0, 0, 0, 0, 1); tick;
    checkOutput("drain_valid", 32'(outValid4), 32'd0);
    checkOutput("drain_err3",  32'(selErr3), 32'd1);

    // Backpressure stream of channels 0,1,2,3
`ifdef PIPE_MUX_SKID_EN
    applyStimulus(0, 0, 1, 0, 1); tick;
    checkOutput("bp0_data",  dataOut4, 32'h11111111);
    checkOutput("bp0_ready", 32'(inReady4), 32'd1);
    applyStimulus(0, 0, 1, 1, 0); tick;
    checkOutput("bp1_data",  dataOut4, 32'h11111111);
    checkOutput("bp1_ready", 32'(inReady4), 32'd0);
    applyStimulus(0, 0, 1, 2, 0); tick;
    checkOutput("bp2_data",  dataOut4, 32'h11111111);
    checkOutput("bp2_ready", 32'(inReady4), 32'd0);
    applyStimulus(0, 0, 1, 2, 0); tick;
    checkOutput("bp3_data",  dataOut4, 32'h11111111);
    checkOutput("bp3_valid", 32'(outValid4), 32'd1);
    applyStimulus(0, 0, 1, 2, 1); tick;
    checkOutput("bp4_data",  dataOut4, 32'h22222222);
    checkOutput("bp4_ready", 32'(inReady4), 32'd1);
    applyStimulus(0, 0, 1, 2, 1); tick;
    checkOutput("bp5_data", dataOut4, 32'h33333333);
    applyStimulus(0, 0, 1, 3, 1); tick;
    checkOutput("bp6_data", dataOut4, 32'h44444444);
    applyStimulus(0, 0, 0, 0, 1); tick;
    checkOutput("bp7_valid", 32'(outValid4), 32'd0);
`else
    applyStimulus(0, 0, 1, 0, 1); tick;
    checkOutput("bp0_data", dataOut4, 32'h11111111);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("bp1_comb_ready", 32'(inReady4), 32'd0);
    tick;
    checkOutput("bp1_data",  dataOut4, 32'h11111111);
    checkOutput("bp1_valid", 32'(outValid4), 32'd1);
    applyStimulus(0, 0, 1, 1, 0); tick;
    checkOutput("bp2_data", dataOut4, 32'h11111111);
    applyStimulus(0, 0, 1, 1, 1);
    checkOutput("bp3_comb_ready", 32'(inReady4), 32'd1);
    tick;
    checkOutput("bp3_data", dataOut4, 32'h22222222);
    applyStimulus(0, 0, 1, 2, 1); tick;
    checkOutput("bp4_data", dataOut4, 32'h33333333);
    applyStimulus(0, 0, 1, 3, 1); tick;
    checkOutput("bp5_data", dataOut4, 32'h44444444);
    applyStimulus(0, 0, 0, 0, 1); tick;
    checkOutput("bp6_valid", 32'(outValid4), 32'd0);
`endif

    // Clear the sticky error before the flush checks
    applyStimulus(1, 0, 0, 0, 1); tick;
    checkOutput("rst2_err3", 32'(selErr3), 32'd0);

    // Flush with held beats and a simultaneous input beat
`ifdef PIPE_MUX_SKID_EN
    applyStimulus(0, 0, 1, 0, 0); tick;
    applyStimulus(0, 0, 1, 1, 0); tick;
    checkOutput("fl_two_ready", 32'(inReady4), 32'd0);
    checkOutput("fl_two_valid", 32'(outValid4), 32'd1);
    applyStimulus(0, 1, 1, 2, 0); tick;
`else
    applyStimulus(0, 0, 1, 0, 0); tick;
    checkOutput("fl_held_valid", 32'(outValid4), 32'd1);
    applyStimulus(0, 1, 1, 1, 1); tick;
`endif
    checkOutput("fl_valid", 32'(outValid4), 32'd0);
    checkOutput("fl_ready", 32'(inReady4), 32'd1);
    applyStimulus(0, 0, 0, 0, 1); tick;
    checkOutput("fl_after_valid", 32'(outValid4), 32'd0);

    // A bad select discarded by flush still raises the error
    applyStimulus(0, 1, 1, 3, 0); tick;
    checkOutput("flerr_err3",   32'(selErr3), 32'd1);
    checkOutput("flerr_valid3", 32'(outValid3), 32'd0);
    checkOutput("flerr_err4",   32'(selErr4), 32'd0);

    // Reset mid-stream
    applyStimulus(0, 0, 1, 3, 0); tick;
    checkOutput("mid_valid4", 32'(outValid4), 32'd1);
    checkOutput("mid_data4",  dataOut4, 32'h44444444);
    applyStimulus(1, 0, 1, 2, 0); tick;
    checkOutput("mrst_valid4", 32'(outValid4), 32'd0);
    checkOutput("mrst_data4",  dataOut4, 32'h0);
    checkOutput("mrst_ready4", 32'(inReady4), 32'd1);
    checkOutput("mrst_err3",   32'(selErr3), 32'd0);
    checkOutput("mrst_valid3", 32'(outValid3), 32'd0);

    applyStimulus(0, 0, 0, 0, 1); tick;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
